// File: rtl/mem_req_master.sv
// mem_req_master -- queued valid/ready memory initiator with one-at-a-time issue and timeout abort.
// Revision 1.0
`default_nettype none

module mem_req_master #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr_rd,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [WIDTH-1:0]      cmd_wdata,
  output logic                  valid,
  input  logic                  ready,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH-1:0]      rdata,
  output logic                  rsp_valid,
  output logic                  rsp_wr_rd,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = $clog2(DEPTH + 1);
  localparam int C_TMO_W = $clog2(TIMEOUT + 1);
  localparam int C_ENT_W = 1 + ADDR_WIDTH + WIDTH;

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_REQ  = 2'd1;
  localparam logic [1:0] C_GAP  = 2'd2;

  logic [C_ENT_W-1:0]    r_fifo [DEPTH];
  logic [C_PTR_W-1:0]    r_wr_ptr;
  logic [C_PTR_W-1:0]    r_rd_ptr;
  logic [C_CNT_W-1:0]    r_count;
  logic [1:0]            r_state;
  logic [C_TMO_W-1:0]    r_tmo;

  logic                  r_valid;
  logic                  r_wr_rd;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata;
  logic                  r_rsp_valid;
  logic                  r_rsp_wr_rd;
  logic [ADDR_WIDTH-1:0] r_rsp_addr;
  logic [WIDTH-1:0]      r_rsp_rdata;
  logic                  r_rsp_err;

  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [C_ENT_W-1:0]    w_head;
  logic [WIDTH-1:0]      w_store_wdata;
  logic [C_TMO_W-1:0]    w_tmo_inc;

  assign w_full        = (r_count == C_CNT_W'(DEPTH));
  assign w_push        = cmd_valid && !w_full;
  // Pop only from IDLE, and only what was already stored: no same-cycle bypass.
  assign w_pop         = (r_state == C_IDLE) && (r_count != '0);
  assign w_head        = r_fifo[r_rd_ptr];
  assign w_store_wdata = cmd_wr_rd ? cmd_wdata : '0;
  assign w_tmo_inc     = (r_tmo == C_TMO_W'(TIMEOUT)) ? r_tmo : r_tmo + C_TMO_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_fifo[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= {cmd_wr_rd, cmd_addr, w_store_wdata};
        r_wr_ptr         <= r_wr_ptr + C_PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= C_IDLE;
      r_tmo       <= '0;
      r_valid     <= 1'b0;
      r_wr_rd     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_wr_rd <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        C_IDLE: begin
          r_tmo <= '0;
          if (w_pop) begin
            r_valid <= 1'b1;
            r_wr_rd <= w_head[C_ENT_W-1];
            r_addr  <= w_head[C_ENT_W-2 -: ADDR_WIDTH];
            r_wdata <= w_head[WIDTH-1:0];
            r_state <= C_REQ;
          end
        end
        C_REQ: begin
          if (ready || (w_tmo_inc == C_TMO_W'(TIMEOUT))) begin
            // Either a normal completion or a timeout abort; both end the transfer.
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= !ready;
            r_rsp_wr_rd <= r_wr_rd;
            r_rsp_addr  <= r_addr;
            r_rsp_rdata <= (ready && !r_wr_rd) ? rdata : '0;
            r_valid     <= 1'b0;
            r_wr_rd     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_state     <= C_GAP;
          end
          r_tmo <= ready ? r_tmo : w_tmo_inc;
        end
        C_GAP: begin
          r_tmo   <= '0;
          r_state <= C_IDLE;
        end
        default: begin
          r_tmo   <= '0;
          r_state <= C_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = !w_full;
  assign busy      = (r_count != '0) || (r_state != C_IDLE);
  assign valid     = r_valid;
  assign wr_rd     = r_wr_rd;
  assign addr      = r_addr;
  assign wdata     = r_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_wr_rd = r_rsp_wr_rd;
  assign rsp_addr  = r_rsp_addr;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_req_master.sv
// tb_mem_req_master -- scoreboard bench for mem_req_master with a small memory responder.
// Revision 1.0
`default_nettype none

module tb_mem_req_master;

  localparam int W  = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_wr_rd;
  logic [AW-1:0] cmd_addr;
  logic [W-1:0]  cmd_wdata;
  logic          valid, ready, wr_rd;
  logic [AW-1:0] addr;
  logic [W-1:0]  wdata, rdata;
  logic          rsp_valid, rsp_wr_rd, rsp_err, busy;
  logic [AW-1:0] rsp_addr;
  logic [W-1:0]  rsp_rdata;

  always #5 clk = ~clk;

  mem_req_master #(.WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr_rd(cmd_wr_rd),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .valid(valid), .ready(ready), .wr_rd(wr_rd), .addr(addr), .wdata(wdata), .rdata(rdata),
    .rsp_valid(rsp_valid), .rsp_wr_rd(rsp_wr_rd), .rsp_addr(rsp_addr),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct { logic wr; logic [AW-1:0] addr; logic [W-1:0] data; int len; } req_t;
  typedef struct { logic wr; logic [AW-1:0] addr; logic [W-1:0] rdata; logic err; } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rsp_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Memory responder: ready one cycle after valid, unless held/stuck; spur forces ready.
  logic [W-1:0] mem [32];
  bit           hold = 1'b0, stuck_en = 1'b0, spur = 1'b0;
  logic [AW-1:0] stuck_addr = '0;
  int           vcnt = 0;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[14] = 8'd21;
    ready = 1'b0;
    rdata = 8'h5a;
    forever begin
      @(negedge clk);
      if (rst_n && valid && ready && wr_rd) mem[addr] = wdata;
      @(posedge clk);
      #1;
      if (rst_n && valid) vcnt++; else vcnt = 0;
      if ((vcnt >= 2 && !hold && !(stuck_en && addr == stuck_addr)) || spur) begin
        ready = 1'b1;
        rdata = mem[addr];
      end else begin
        ready = 1'b0;
        rdata = 8'h5a;
      end
    end
  end

  // Monitor: checks request fields, valid duration and every completion against the queues.
  req_t cur;
  int   vlen = 0;
  bit   in_req = 1'b0;
  bit   prev_rsp = 1'b0;
  rsp_t r;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_req   = 1'b0;
      vlen     = 0;
      prev_rsp = 1'b0;
    end else begin
      if (valid) begin
        if (!in_req) begin
          in_req = 1'b1;
          vlen   = 0;
          if (req_q.size() == 0) begin
            fail("unexpected_req");
            cur = '{wr_rd, addr, wdata, 0};
          end else begin
            cur = req_q.pop_front();
          end
        end
        check("req_fields", {wr_rd, addr, wdata}, {cur.wr, cur.addr, cur.data});
        vlen++;
      end else if (in_req) begin
        in_req = 1'b0;
        if (cur.len != 0) check("valid_len", vlen, cur.len);
      end
      if (rsp_valid) begin
        check("rsp_single_pulse", prev_rsp, 0);
        if (rsp_q.size() == 0) begin
          fail("unexpected_rsp");
        end else begin
          r = rsp_q.pop_front();
          check("rsp_wr_rd", rsp_wr_rd, r.wr);
          check("rsp_addr", rsp_addr, r.addr);
          check("rsp_rdata", rsp_rdata, r.rdata);
          check("rsp_err", rsp_err, r.err);
          rsp_seen++;
        end
      end
      prev_rsp = rsp_valid;
    end
  end

  // Drive one command (called at posedge+1), wait until taken, then queue its expectations.
  task automatic send(input bit wr, input logic [AW-1:0] a, input logic [W-1:0] d,
                      input logic [W-1:0] exp_rd, input bit exp_err, input int exp_len);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_wr_rd = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      fail("cmd_accept_timeout");
    end else begin
      req_q.push_back('{wr, a, (wr ? d : 8'h00), exp_len});
      rsp_q.push_back('{wr, a, exp_rd, exp_err});
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((busy || rsp_q.size() != 0) && n < 300);
    if (n >= 300) fail("idle_timeout");
  endtask

  int base;

  initial begin
    cmd_valid = 1'b0;
    cmd_wr_rd = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rst_n     = 1'b0;

    // Reset with ready toggling
    repeat (3) begin
      @(posedge clk);
      #1;
      spur = ~spur;
    end
    @(negedge clk);
    check("reset_req", {valid, wr_rd, addr, wdata}, 0);
    check("reset_rsp", {rsp_valid, rsp_wr_rd, rsp_addr, rsp_rdata, rsp_err}, 0);
    check("reset_busy", busy, 0);
    check("reset_no_x", $isunknown({cmd_ready, valid, wr_rd, addr, wdata, rsp_valid,
                                    rsp_wr_rd, rsp_addr, rsp_rdata, rsp_err, busy}), 0);
    spur = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_cmd_ready", cmd_ready, 1);
    check("post_reset_busy", busy, 0);
    @(posedge clk);
    #1;

    // Single write then read-back
    send(1'b1, 5'd31, 8'd226, 8'd0, 1'b0, 2);
    wait_idle();
    send(1'b0, 5'd31, 8'h77, 8'd226, 1'b0, 2);
    wait_idle();

    // FIFO full with the memory stalled
    hold = 1'b1;
    send(1'b1, 5'd0,  8'h10, 8'd0, 1'b0, 0);
    send(1'b1, 5'd9,  8'h19, 8'd0, 1'b0, 2);
    send(1'b1, 5'd4,  8'h14, 8'd0, 1'b0, 2);
    send(1'b1, 5'd18, 8'h28, 8'd0, 1'b0, 2);
    send(1'b1, 5'd28, 8'h38, 8'd0, 1'b0, 2);
    check("full_cmd_ready", cmd_ready, 0);
    base = rsp_seen;
    cmd_valid = 1'b1;
    cmd_wr_rd = 1'b1;
    cmd_addr  = 5'd7;
    cmd_wdata = 8'h47;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("full_stall", cmd_ready, 0);
    end
    hold = 1'b0;
    send(1'b1, 5'd7, 8'h47, 8'd0, 1'b0, 2);
    check("sixth_after_first_done", (rsp_seen - base) >= 1, 1);
    wait_idle();

    // Timeout on a read, then a normal command behind it
    stuck_en   = 1'b1;
    stuck_addr = 5'd3;
    send(1'b0, 5'd3, 8'hAA, 8'd0, 1'b1, 15);
    send(1'b1, 5'd5, 8'h55, 8'd0, 1'b0, 2);
    wait_idle();
    stuck_en = 1'b0;

    // Reset while in REQ with two commands queued
    hold = 1'b1;
    send(1'b1, 5'd1, 8'h11, 8'd0, 1'b0, 0);
    send(1'b1, 5'd2, 8'h22, 8'd0, 1'b0, 0);
    send(1'b0, 5'd6, 8'h66, 8'd0, 1'b0, 0);
    @(posedge clk);
    #1;
    check("pre_reset_in_req", valid, 1);
    rst_n = 1'b0;
    #1;
    check("midreset_valid", valid, 0);
    check("midreset_busy", busy, 0);
    check("midreset_rsp_valid", rsp_valid, 0);
    req_q.delete();
    rsp_q.delete();
    hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = rsp_seen;
    repeat (3) @(posedge clk);
    #1;
    check("no_rsp_after_reset", rsp_seen - base, 0);
    send(1'b1, 5'd9, 8'd180, 8'd0, 1'b0, 2);
    wait_idle();

    // Spurious ready while idle
    base = rsp_seen;
    spur = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    spur = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("spur_no_rsp", rsp_seen - base, 0);
    check("spur_idle", {busy, valid}, 0);
    send(1'b0, 5'd14, 8'h3C, 8'd21, 1'b0, 2);
    wait_idle();

    check("all_rsp_drained", rsp_q.size(), 0);
    check("all_req_drained", req_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/mem_req_master.md
Name: mem_req_master

Overview:
- Synthesizable initiator for the memory valid/ready interface. Drives wr_rd, addr, wdata and valid toward the memory, and collects rdata.
- Accepts write and read commands from an upstream command port and buffers them in a small FIFO.
- Issues one memory transfer at a time and returns a completion response for each command.
- Guarantees the memory-side protocol: all outputs zero in reset and when idle, no X on any output, valid held until ready, and a timeout abort if ready never arrives.

Parameters:
WIDTH, 8, data width of wdata/rdata/cmd_wdata/rsp_rdata
ADDR_WIDTH, 5, address width
DEPTH, 4, command FIFO entries (power of 2, >=2)
TIMEOUT, 15, max cycles in REQ without ready before abort (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
cmd_valid  in  1  upstream command present
cmd_ready  out  1  FIFO not full
cmd_wr_rd  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  command address
cmd_wdata  in  WIDTH  write data (ignored for reads)
valid  out  1  memory request valid
ready  in  1  memory acknowledge
wr_rd  out  1  memory write/read select
addr  out  ADDR_WIDTH  memory address
wdata  out  WIDTH  memory write data
rdata  in  WIDTH  memory read data, valid with ready
rsp_valid  out  1  one-cycle completion pulse
rsp_wr_rd  out  1  type of completed command
rsp_addr  out  ADDR_WIDTH  address of completed command
rsp_rdata  out  WIDTH  read data (0 for writes and errored commands)
rsp_err  out  1  completion was a timeout abort
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (rst=0, async): FIFO emptied, pointers and count cleared, FSM=IDLE, timeout counter=0. All outputs 0 immediately: valid, wr_rd, addr, wdata, rsp_*, busy. cmd_ready=1 after reset deasserts.
- All outputs are registered except cmd_ready (=count!=DEPTH) and busy.
- FIFO push: on cmd_valid && cmd_ready, store {wr_rd, addr, wdata}.
  - wdata is stored as 0 for reads.
  - When full, cmd_ready=0 and the command is not taken; the producer must hold it.
  - No bypass: a command pushed at edge N is poppable at edge N+1 at the earliest.
  - Push and pop in the same cycle leave count unchanged.
- FSM:
  - IDLE: valid/wr_rd/addr/wdata=0. If FIFO non-empty, pop the head, load wr_rd/addr/wdata, set valid=1 and go to REQ.
  - REQ: hold valid=1 and all request fields stable. Sample ready every edge.
    - On ready=1: complete. For reads, capture rdata into rsp_rdata. Set rsp_valid=1, rsp_err=0, rsp_wr_rd/rsp_addr from the request. Clear valid/wr_rd/addr/wdata. Go to GAP.
    - On ready=0: increment the timeout counter. When it reaches TIMEOUT, abort: rsp_valid=1, rsp_err=1, rsp_rdata=0, clear request outputs, go to GAP.
  - GAP: exactly one cycle with valid and all request fields 0. rsp_valid returns to 0. Counter cleared. Go to IDLE.
- Timing: valid rises one edge after the command is visible in the FIFO. With a memory that raises ready one cycle after valid, valid is high for 2 cycles. Back-to-back commands are spaced 4 edges apart (IDLE, REQ, REQ, GAP). valid is never high in two transfers without an intervening zero cycle.
- rsp_valid is a single-cycle pulse with no backpressure. rsp_* fields hold their last values until the next completion.
- ready sampled high outside REQ is ignored and causes no state change.
- A command may be pushed during any FSM state, including during a completion edge.
- Reset mid-REQ: valid drops asynchronously, the in-flight and queued commands are discarded, and no response is generated.
- The timeout counter is sized ceil(log2(TIMEOUT+1)) bits and saturates. Address/data are passed unmodified; no arithmetic on payload.

Test Plan:
- Reset: hold rst=0 for 3 cycles with ready toggling -> valid=wr_rd=addr=wdata=0, rsp_valid=0, cmd_ready=1, busy=0; no X on any output.
- Single write, then read: write addr=31 wdata=226, memory ready 1 cycle after valid -> valid high exactly 2 cycles with addr=31 wdata=226 wr_rd=1, then 1 zero cycle, rsp_valid pulse rsp_wr_rd=1 rsp_err=0. Read addr=31 with memory returning 226 -> rsp_rdata=226, wdata driven 0 throughout.
- FIFO full: with ready held 0, push writes to addr 0, 9, 4, 18, 28 -> first pops to REQ; entries 9, 4, 18, 28 fill the FIFO and cmd_ready=0; a 6th command is stalled until the first completes. Completions arrive in order 0, 9, 4, 18, 28.
- Timeout: read addr=3 with ready stuck 0 -> valid high exactly TIMEOUT=15 cycles, then rsp_valid=1 rsp_err=1 rsp_rdata=0 rsp_addr=3, then one zero cycle. The next queued command issues normally.
- Reset mid-operation: rst=0 while in REQ with 2 commands queued -> valid=0 immediately, no rsp_valid, busy=0; after release, a new write addr=9 wdata=180 completes normally.
- Spurious ready: pulse ready=1 while IDLE with the FIFO empty -> no rsp_valid and no state change; a subsequent read addr=14 returning 21 gives rsp_rdata=21.
